// File: rtl/fft_spectrum_reader_pkg.sv
// Shared definitions for the fft_calc spectrum reader.
// Holds the sweep FSM encoding, the default geometry and its derived
// constants, and small helpers used to size counters from parameters.
package fft_spectrum_reader_pkg;

  // Default geometry: 256 bins folded into 16 bands of 8-bit level.
  localparam int unsigned NUM_BINS_DEF = 256;
  localparam int unsigned BANDS_DEF    = 16;
  localparam int unsigned OUT_W_DEF    = 8;

  localparam int unsigned BIN_SHIFT = $clog2(NUM_BINS_DEF / BANDS_DEF);
  localparam int unsigned BAND_W    = $clog2(BANDS_DEF);
  localparam int unsigned LEVEL_MAX = (1 << OUT_W_DEF) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StEmit
  } state_e;

  // log2 of bins per band for a given geometry.
  function automatic int unsigned bin_shift(input int unsigned num_bins,
                                            input int unsigned bands);
    return $clog2(num_bins / bands);
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_band_max.sv
// Per-band running maximum and level saturation.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid          a captured sample is present this cycle
//   in_bin            bin number of that sample
//   in_sample         unsigned magnitude of that sample
//   in_last           sample is the last bin of its band
//   wr_en             level for wr_band is ready (last bin of a band)
//   wr_band           band index derived from in_bin
//   wr_level          min(max >> SHIFT, 2^OUT_W-1) including this sample
module fft_band_max #(
  parameter int unsigned FREQ_W    = 9,
  parameter int unsigned SAMPLE_W  = 19,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned SHIFT     = 11,
  parameter int unsigned BIN_SHIFT = 4,
  parameter int unsigned BAND_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [FREQ_W-1:0]   in_bin,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_last,
  output logic                wr_en,
  output logic [BAND_W-1:0]   wr_band,
  output logic [OUT_W-1:0]    wr_level
);

  localparam logic [SAMPLE_W-1:0] SatLim = SAMPLE_W'((1 << OUT_W) - 1);

  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [SAMPLE_W-1:0] mag, cur, scaled;

  always_comb begin
    // Bin 0 is DC and never contributes to a band.
    mag      = (in_bin == '0) ? '0 : in_sample;
    cur      = (mag > max_q) ? mag : max_q;
    scaled   = cur >> SHIFT;
    wr_level = (scaled > SatLim) ? OUT_W'(SatLim) : scaled[OUT_W-1:0];
    wr_en    = in_valid && in_last;
    wr_band  = BAND_W'(in_bin >> BIN_SHIFT);
    max_d    = max_q;
    if (in_valid) begin
      max_d = in_last ? '0 : cur;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/fft_spectrum_reader.sv
// Reads a finished spectrum from fft_calc and streams per-band levels.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   frame_done   pulse: a new spectrum is ready in fft_calc
//   frequency    bin address presented to fft_calc
//   sample       magnitude for the address presented READ_LAT cycles earlier
//   band_idx     band index on the output stream
//   band_level   band level on the output stream
//   band_valid   output stream valid
//   band_ready   output stream ready
//   busy         reader is not idle
//   overrun      sticky: frame_done seen while not idle
module fft_spectrum_reader
  import fft_spectrum_reader_pkg::*;
#(
  parameter int unsigned FREQ_W   = 9,
  parameter int unsigned SAMPLE_W = 19,
  parameter int unsigned NUM_BINS = NUM_BINS_DEF,
  parameter int unsigned BANDS    = BANDS_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned SHIFT    = 11,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_done,
  output logic [FREQ_W-1:0]        frequency,
  input  logic [SAMPLE_W-1:0]      sample,
  output logic [$clog2(BANDS)-1:0] band_idx,
  output logic [OUT_W-1:0]         band_level,
  output logic                     band_valid,
  input  logic                     band_ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned BinShift = bin_shift(NUM_BINS, BANDS);
  localparam int unsigned BandW    = $clog2(BANDS);
  localparam int unsigned DrainW   = cnt_w(READ_LAT);
  localparam logic [FREQ_W-1:0] BinMask = FREQ_W'((1 << BinShift) - 1);

  state_e              state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic [BandW-1:0]    idx_q, idx_d;
  logic                overrun_q;

  // Address pipe matching the fft_calc read latency.
  logic [READ_LAT-1:0] pipe_vld_q;
  logic [FREQ_W-1:0]   pipe_bin_q [READ_LAT];
  logic [OUT_W-1:0]    buf_q [BANDS];

  logic                tail_vld, tail_last;
  logic [FREQ_W-1:0]   tail_bin;
  logic                wr_en;
  logic [BandW-1:0]    wr_band;
  logic [OUT_W-1:0]    wr_level;

  assign tail_vld  = pipe_vld_q[READ_LAT-1];
  assign tail_bin  = pipe_bin_q[READ_LAT-1];
  assign tail_last = (tail_bin & BinMask) == BinMask;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (frame_done) begin
          state_d = StSweep;
          freq_d  = '0;
        end
      end
      StSweep: begin
        if (freq_q == FREQ_W'(NUM_BINS - 1)) begin
          state_d = StDrain;
          freq_d  = '0;
          drain_d = '0;
        end else begin
          freq_d = freq_q + 1'b1;
        end
      end
      StDrain: begin
        // Last drain cycle consumes the final bin and writes the last band.
        if (drain_q == DrainW'(READ_LAT - 1)) begin
          state_d = StEmit;
          idx_d   = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StEmit: begin
        if (band_ready) begin
          if (idx_q == BandW'(BANDS - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      freq_q    <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_q | (frame_done && (state_q != StIdle));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_bin_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= (state_q == StSweep);
      pipe_bin_q[0] <= freq_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_bin_q[i] <= pipe_bin_q[i-1];
      end
    end
  end

  fft_band_max #(
    .FREQ_W   (FREQ_W),
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT),
    .BIN_SHIFT(BinShift),
    .BAND_W   (BandW)
  ) u_band_max (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tail_vld),
    .in_bin   (tail_bin),
    .in_sample(sample),
    .in_last  (tail_last),
    .wr_en    (wr_en),
    .wr_band  (wr_band),
    .wr_level (wr_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BANDS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_en) begin
      buf_q[wr_band] <= wr_level;
    end
  end

  assign frequency  = freq_q;
  assign band_idx   = idx_q;
  assign band_valid = (state_q == StEmit);
  assign band_level = band_valid ? buf_q[idx_q] : '0;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule

// File: doc/fft_spectrum_reader.md
Name: fft_spectrum_reader

Overview:
Reads a completed spectrum out of fft_calc's result port and emits per-band levels for the clock's display.
- Sweeps the fft_calc `frequency` address, captures the returned `sample` after a fixed read latency, and max-reduces bins into bands.
- Emits one saturated level per band on a valid/ready stream.
- Sits between fft_calc and the display driver.

Parameters:
FREQ_W, 9, width of frequency address to fft_calc
SAMPLE_W, 19, width of unsigned magnitude returned by fft_calc
NUM_BINS, 256, bins swept per frame (positive-frequency half), addresses 0..NUM_BINS-1
BANDS, 16, output bands; NUM_BINS/BANDS must be a power of two (bins per band = 16 at defaults)
OUT_W, 8, band level width
SHIFT, 11, right shift applied to band max before saturation
READ_LAT, 2, cycles from frequency change to matching sample at input

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
frame_done  in  1  single-cycle pulse: fft_calc has a new spectrum ready
frequency  out  FREQ_W  bin address to fft_calc
sample  in  SAMPLE_W  magnitude for the address presented READ_LAT cycles earlier
band_idx  out  log2(BANDS)  index of band on output
band_level  out  OUT_W  band level
band_valid  out  1  band_idx/band_level valid
band_ready  in  1  downstream accepts
busy  out  1  high in any state but IDLE
overrun  out  1  sticky: frame_done arrived while busy

Behaviour:
- Reset (rst low, async): frequency=0, band_idx=0, band_level=0, band_valid=0, busy=0, overrun=0, FSM=IDLE, running max=0.
- FSM states: IDLE, SWEEP, DRAIN, EMIT.
- IDLE -> SWEEP on frame_done. frequency=0 in the first SWEEP cycle.
- SWEEP: frequency increments by 1 every cycle. After NUM_BINS-1 is presented -> DRAIN; frequency returns to 0.
- Capture pipeline: a READ_LAT-deep shift register carries {valid, bin}. Sample is consumed when the pipe tail is valid.
- DRAIN: lasts READ_LAT cycles until the pipe empties, then -> EMIT.
- Reduction: band = bin >> log2(NUM_BINS/BANDS). Bin 0 (DC) is treated as sample=0. Running max is compared as unsigned.
- On the last bin of a band, level = min(max >> SHIFT, 2^OUT_W-1) is written into result buffer[band], and max resets to 0. The write for the final band occurs no later than the last DRAIN cycle.
- EMIT: streams buffer[0..BANDS-1] in order, with band_idx equal to the buffer index.
  - band_valid rises the first EMIT cycle.
  - A transfer occurs when band_valid && band_ready; on a transfer, advance.
  - While band_valid && !band_ready, band_idx/band_level are held stable.
  - After the transfer of band BANDS-1: band_valid=0 and -> IDLE the next cycle.
- frame_done in any state but IDLE: ignored, overrun set to 1. overrun clears only on reset.
- frame_done coincident with the final EMIT transfer is also ignored and flags overrun.
- Total latency, frame_done to first band_valid: 1 + NUM_BINS + READ_LAT cycles (259 at defaults).
- Throughput: with band_ready held high, one band per cycle.
- No wrap-around of frequency beyond NUM_BINS-1. The top bit of frequency is always 0 at defaults.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Localparams BIN_SHIFT = log2(NUM_BINS/BANDS), BAND_W = log2(BANDS), LEVEL_MAX.
- One natural sub-module: fft_band_max, the per-band running-max-and-saturate stage. It takes a valid sample, bin number and last-of-band flag, and produces a write strobe, band index and level.
- The sweep FSM, latency pipe, result buffer and emit stream stay in the top.

Test Plan:
1. Reset check: assert rst low mid-run -> all outputs 0 immediately (asynchronous). After release with no frame_done, the block stays IDLE with busy=0.
2. Ramp spectrum: fft model returns sample = bin << 11, with READ_LAT=2.
   - Stimulus: frame_done pulse, band_ready=1.
   - Required: first band_valid 259 cycles after the pulse; band b has level 16b+15; band 0 reports 15 (DC zeroed); exactly 16 beats, then busy=0.
3. Single tone: sample = 0x7FFFF at bin 37, else 0 -> band 2 level 255 (saturated), all other bands 0.
4. Backpressure: ramp spectrum with band_ready toggling 1,0,0,1 repeatedly.
   - Every band is accepted exactly once, in order, with the same values as scenario 2.
   - band_idx/band_level stay constant on every valid-but-not-ready cycle.
5. Overrun: second frame_done 100 cycles into SWEEP -> overrun=1 and stays 1. Band outputs are identical to scenario 2 and there is no restart.
6. Reset mid-sweep: rst low at bin 120, released, then a new frame_done with the ramp model -> a clean 16-band output matching scenario 2, and overrun=0.
